// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Purpose:
//   Routes a single valid/ready input stream onto one of N = 2**SEL_W output
//   channels. One beat is held in an output register and presented on the
//   shared out_data bus together with a one-hot out_valid. Two routing modes
//   are supported:
//     mode = 0 : every beat picks its own channel through in_sel.
//     mode = 1 : the first beat of a burst picks the channel and the burst
//                length (in_len = beats minus one). The remaining beats of the
//                burst follow that channel regardless of in_sel/in_len/mode.
//   Beats routed to a channel whose chan_en bit is low are still accepted but
//   discarded, and each one bumps a saturating drop counter.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_data    in   DATA_W   input payload
//   in_valid   in   1        input beat present
//   in_ready   out  1        block accepts a beat this cycle
//   in_sel     in   SEL_W    destination channel
//   in_len     in   LEN_W    burst beats minus one
//   mode       in   1        0 = per-beat select, 1 = burst select
//   chan_en    in   N        per-channel enable mask
//   out_data   out  DATA_W   payload, shared by all channels
//   out_valid  out  N        one-hot valid, all zero when empty
//   out_ready  in   N        per-channel ready
//   busy       out  1        high while a burst is in progress
//   drop_cnt   out  CNT_W    beats dropped to disabled channels
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16,
  localparam int N     = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              mode,
  input  logic [N-1:0]      chan_en,
  output logic [DATA_W-1:0] out_data,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]        r_state;
  logic              r_hv;
  logic [SEL_W-1:0]  r_hch;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_burst_ch;
  logic [LEN_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_accept;
  logic              w_drain;
  logic [SEL_W-1:0]  w_dch;
  logic              w_dch_en;
  logic              w_start_burst;
  logic              w_end_burst;

  // The holding register can take a new beat when it is empty or when its
  // current beat leaves this very cycle. Reset forces ready high so the
  // upstream never sees a stall while the block is being cleared; the reset
  // branch of the sequential logic still keeps that beat from being taken.
  always_comb begin
    in_ready = rst | ~r_hv | out_ready[r_hch];
  end

  // Handshake qualifiers. A beat is only really accepted outside reset, so
  // drop counting and FSM movement are all keyed off w_accept.
  always_comb begin
    w_accept = in_valid & in_ready & ~rst;
    w_drain  = r_hv & out_ready[r_hch];
  end

  // Destination selection: inside a burst the channel latched by the first
  // beat wins and in_sel/mode are ignored; otherwise in_sel picks directly.
  always_comb begin
    w_dch = in_sel;
    if (r_state == ST_BURST) begin
      w_dch = r_burst_ch;
    end
    w_dch_en = chan_en[w_dch];
  end

  // Burst boundaries. A burst starts from IDLE on a burst-mode beat with a
  // non-zero length (zero length is just a single routed beat), and ends on
  // the beat accepted when one beat is still outstanding.
  always_comb begin
    w_start_burst = w_accept & (r_state == ST_IDLE) & mode & (in_len != '0);
    w_end_burst   = w_accept & (r_state == ST_BURST) & (r_rem == LEN_W'(1));
  end

  // Routing FSM. rem counts the beats still owed to the latched channel
  // after the one being accepted, so a burst of in_len+1 beats stays in
  // BURST for exactly in_len accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_burst_ch <= '0;
      r_rem      <= '0;
    end else begin
      if (w_start_burst) begin
        r_state    <= ST_BURST;
        r_burst_ch <= in_sel;
        r_rem      <= in_len;
      end else if (w_end_burst) begin
        r_state <= ST_IDLE;
        r_rem   <= '0;
      end else if (w_accept && (r_state == ST_BURST)) begin
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

  // Holding register. A beat to an enabled channel loads it, which also
  // covers the drain-and-reload case at full throughput. A beat to a
  // disabled channel never touches it, so whatever is already held keeps
  // going out; if it drains in that same cycle the register empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hv   <= 1'b0;
      r_hch  <= '0;
      r_data <= '0;
    end else begin
      if (w_accept && w_dch_en) begin
        r_hv   <= 1'b1;
        r_hch  <= w_dch;
        r_data <= in_data;
      end else if (w_drain) begin
        r_hv <= 1'b0;
      end
    end
  end

  // Drop counter: one increment per accepted beat whose channel is
  // disabled at acceptance time, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_accept && !w_dch_en && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  // Output decode: a single held beat drives one bit of the one-hot valid
  // vector; the data bus is shared and simply reflects the held payload.
  always_comb begin
    out_valid = '0;
    if (r_hv) begin
      out_valid[r_hch] = 1'b1;
    end
    out_data = r_data;
    busy     = (r_state == ST_BURST);
    drop_cnt = r_drop_cnt;
  end

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Purpose:
//   Self-checking bench for stream_demux with default parameters. Expected
//   deliveries (channel + payload) are queued when a beat is driven and are
//   popped and compared by a monitor whenever an output handshake occurs.
//   Directed checks cover reset state, latency, back-pressure, burst routing,
//   disabled-channel drops, mid-burst reset and drop counter saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_demux;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 16;
  localparam int N      = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [LEN_W-1:0]  in_len;
  logic              mode;
  logic [N-1:0]      chan_en;
  logic [DATA_W-1:0] out_data;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic              busy;
  logic [CNT_W-1:0]  drop_cnt;

  int assertCount = 0;
  int failCount   = 0;

  logic [10:0] expQueue[$];

  stream_demux #(
    .DATA_W(DATA_W),
    .SEL_W (SEL_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_len   (in_len),
    .mode     (mode),
    .chan_en  (chan_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges far beyond the expected run length.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue a beat the bench expects to come out of the given channel.
  task automatic expectBeat(input logic [2:0] ch, input logic [7:0] d);
    expQueue.push_back({ch, d});
  endtask

  // Drive one beat and hold it until accepted (bounded), returning 1 ns
  // after the accepting edge so the next call can follow back to back.
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s,
                               input logic [3:0] l, input logic m);
    int waitCycles;
    in_data  = d;
    in_sel   = s;
    in_len   = l;
    mode     = m;
    in_valid = 1'b1;
    waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 20) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: on every output handshake pop the oldest expected
  // beat and compare channel and payload; any handshake with nothing
  // expected is a failure.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [7:0]  expOneHot;
    if (!rst && ((out_valid & out_ready) != '0)) begin
      if (expQueue.size() == 0) begin
        checkOutput("sb_unexpected", 32'(out_valid), 32'd0);
      end else begin
        e = expQueue.pop_front();
        expOneHot = 8'd1 << e[10:8];
        checkOutput("sb_chan", 32'(out_valid), 32'(expOneHot));
        checkOutput("sb_data", 32'(out_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    int guard;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_len    = '0;
    mode      = 1'b0;
    chan_en   = 8'hFF;
    out_ready = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] per-beat routing and latency");
    expectBeat(3'd2, 8'hA5);
    applyStimulus(8'hA5, 3'd2, 4'd0, 1'b0);
    checkOutput("lat_valid_a5", 32'(out_valid), 32'h04);
    checkOutput("lat_data_a5", 32'(out_data), 32'hA5);
    expectBeat(3'd5, 8'h3C);
    applyStimulus(8'h3C, 3'd5, 4'd0, 1'b0);
    checkOutput("lat_valid_3c", 32'(out_valid), 32'h20);
    checkOutput("lat_data_3c", 32'(out_data), 32'h3C);

    $display("[TB] back-pressure on channel 2");
    out_ready = 8'hFB;
    expectBeat(3'd2, 8'h11);
    applyStimulus(8'h11, 3'd2, 4'd0, 1'b0);
    in_data  = 8'h22;
    in_sel   = 3'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_valid", 32'(out_valid), 32'h04);
      checkOutput("bp_data", 32'(out_data), 32'h11);
    end
    @(posedge clk);
    #1;
    out_ready = 8'hFF;
    expectBeat(3'd3, 8'h22);
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_next_valid", 32'(out_valid), 32'h08);
    checkOutput("bp_next_data", 32'(out_data), 32'h22);

    $display("[TB] burst of four to channel 6");
    expectBeat(3'd6, 8'hB0);
    applyStimulus(8'hB0, 3'd6, 4'd3, 1'b1);
    checkOutput("burst_busy_1", 32'(busy), 32'd1);
    checkOutput("burst_valid_1", 32'(out_valid), 32'h40);
    expectBeat(3'd6, 8'hB1);
    applyStimulus(8'hB1, 3'd1, 4'd0, 1'b1);
    checkOutput("burst_busy_2", 32'(busy), 32'd1);
    checkOutput("burst_valid_2", 32'(out_valid), 32'h40);
    expectBeat(3'd6, 8'hB2);
    applyStimulus(8'hB2, 3'd2, 4'd5, 1'b1);
    checkOutput("burst_busy_3", 32'(busy), 32'd1);
    checkOutput("burst_valid_3", 32'(out_valid), 32'h40);
    expectBeat(3'd6, 8'hB3);
    applyStimulus(8'hB3, 3'd3, 4'd1, 1'b1);
    checkOutput("burst_busy_4", 32'(busy), 32'd0);
    checkOutput("burst_valid_4", 32'(out_valid), 32'h40);
    expectBeat(3'd1, 8'hB4);
    applyStimulus(8'hB4, 3'd1, 4'd0, 1'b0);
    checkOutput("burst_after_valid", 32'(out_valid), 32'h02);

    $display("[TB] zero-length burst is a single beat");
    expectBeat(3'd7, 8'hC0);
    applyStimulus(8'hC0, 3'd7, 4'd0, 1'b1);
    checkOutput("single_busy", 32'(busy), 32'd0);
    checkOutput("single_valid", 32'(out_valid), 32'h80);
    expectBeat(3'd0, 8'hC1);
    applyStimulus(8'hC1, 3'd0, 4'd0, 1'b0);
    checkOutput("single_next_valid", 32'(out_valid), 32'h01);

    $display("[TB] drops to disabled channel 2");
    @(posedge clk);
    #1;
    chan_en = 8'hFB;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hD0 + 8'(i), 3'd2, 4'd0, 1'b0);
      checkOutput("drop_valid", 32'(out_valid), 32'd0);
      checkOutput("drop_in_ready", 32'(in_ready), 32'd1);
    end
    checkOutput("drop_cnt_3", 32'(drop_cnt), 32'd3);

    $display("[TB] burst to disabled channel 5");
    chan_en = 8'hDF;
    applyStimulus(8'hE0, 3'd5, 4'd2, 1'b1);
    checkOutput("dburst_busy_1", 32'(busy), 32'd1);
    applyStimulus(8'hE1, 3'd0, 4'd0, 1'b0);
    checkOutput("dburst_busy_2", 32'(busy), 32'd1);
    applyStimulus(8'hE2, 3'd0, 4'd0, 1'b0);
    checkOutput("dburst_busy_3", 32'(busy), 32'd0);
    checkOutput("dburst_valid", 32'(out_valid), 32'd0);
    checkOutput("dburst_drop_cnt", 32'(drop_cnt), 32'd6);
    chan_en = 8'hFF;

    $display("[TB] reset in the middle of an 8-beat burst");
    expectBeat(3'd1, 8'hF0);
    applyStimulus(8'hF0, 3'd1, 4'd7, 1'b1);
    applyStimulus(8'hF1, 3'd1, 4'd7, 1'b1);
    rst       = 1'b1;
    out_ready = 8'h00;
    in_data   = 8'h99;
    in_sel    = 3'd6;
    mode      = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_in_ready_2", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    rst       = 1'b0;
    out_ready = 8'hFF;
    @(negedge clk);
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_data", 32'(out_data), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    expectBeat(3'd4, 8'h44);
    applyStimulus(8'h44, 3'd4, 4'd0, 1'b0);
    checkOutput("post_rst_valid", 32'(out_valid), 32'h10);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] drop counter saturation");
    @(posedge clk);
    #1;
    chan_en  = 8'h00;
    in_sel   = 3'd0;
    in_len   = 4'd0;
    mode     = 1'b0;
    in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("sat_preload", 32'(drop_cnt), 32'hFFFF);
    applyStimulus(8'h55, 3'd3, 4'd0, 1'b0);
    checkOutput("sat_hold", 32'(drop_cnt), 32'hFFFF);
    checkOutput("sat_valid", 32'(out_valid), 32'd0);

    guard = 0;
    while (expQueue.size() != 0 && guard < 20) begin
      guard++;
      @(posedge clk);
    end
    checkOutput("sb_empty", 32'(expQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
